// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: bus widths, 2-bit FSM encodings and state type.
// Project-wide width/encoding macros get defaults here if not predefined.
`ifndef ADDRESS_INDEX_LIMIT
`define ADDRESS_INDEX_LIMIT 31
`endif
`ifndef DATA_INDEX_LIMIT
`define DATA_INDEX_LIMIT 31
`endif
`ifndef MEM_ARB_ST_IDLE
`define MEM_ARB_ST_IDLE 2'b00
`endif
`ifndef MEM_ARB_ST_ACCESS
`define MEM_ARB_ST_ACCESS 2'b01
`endif
`ifndef MEM_ARB_ST_DONE
`define MEM_ARB_ST_DONE 2'b10
`endif

package mem_arbiter_pkg;

    localparam int AW = `ADDRESS_INDEX_LIMIT + 1;
    localparam int DW = `DATA_INDEX_LIMIT + 1;

    typedef enum logic [1:0] {
        IDLE   = `MEM_ARB_ST_IDLE,
        ACCESS = `MEM_ARB_ST_ACCESS,
        DONE   = `MEM_ARB_ST_DONE
    } state_t;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// arb_select: two-way grant choice; on a tie the requester
// not granted last wins, otherwise the single requester wins.
module arb_select (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_win
);

    logic w_tie;

    assign w_tie = i_req0 & i_req1;
    assign o_win = w_tie ? ~i_last : i_req1;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for a single strobe-timed memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties (default: R0 priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          R0_REQ,
    input  logic          R0_WRITE,
    input  logic [AW-1:0] R0_ADDR,
    input  logic [DW-1:0] R0_WDATA,
    output logic [DW-1:0] R0_RDATA,
    output logic          R0_ACK,
    input  logic          R1_REQ,
    input  logic          R1_WRITE,
    input  logic [AW-1:0] R1_ADDR,
    input  logic [DW-1:0] R1_WDATA,
    output logic [DW-1:0] R1_RDATA,
    output logic          R1_ACK,
    output logic [AW-1:0] ADDR,
    output logic          READ,
    output logic          WRITE,
    inout  wire  [DW-1:0] DATA
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_sel;
    logic          r_wr;
    logic [DW-1:0] r_wdata;

    logic          w_win;
    logic          w_last;
    logic          w_wr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          r_last;
    assign w_last = r_last;
`else
    // Tie input held at 1 makes the selector always favour R0.
    assign w_last = 1'b1;
`endif

    arb_select u_sel (
        .i_req0 (R0_REQ),
        .i_req1 (R1_REQ),
        .i_last (w_last),
        .o_win  (w_win)
    );

    assign w_wr    = w_win ? R1_WRITE : R0_WRITE;
    assign w_addr  = w_win ? R1_ADDR  : R0_ADDR;
    assign w_wdata = w_win ? R1_WDATA : R0_WDATA;

    assign DATA = WRITE ? r_wdata : {DW{1'bz}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_sel    <= 1'b0;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
            ADDR     <= '0;
            READ     <= 1'b0;
            WRITE    <= 1'b0;
            R0_ACK   <= 1'b0;
            R1_ACK   <= 1'b0;
            R0_RDATA <= '0;
            R1_RDATA <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last   <= 1'b1;
`endif
        end else begin
            R0_ACK <= 1'b0;
            R1_ACK <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (R0_REQ | R1_REQ) begin
                        r_sel   <= w_win;
                        r_wr    <= w_wr;
                        r_wdata <= w_wdata;
                        ADDR    <= w_addr;
                        READ    <= ~w_wr;
                        WRITE   <= w_wr;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last  <= w_win;
`endif
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        READ    <= 1'b0;
                        WRITE   <= 1'b0;
                        r_state <= DONE;
                        if (!r_wr && !r_sel) R0_RDATA <= DATA;
                        if (!r_wr &&  r_sel) R1_RDATA <= DATA;
                        if (r_sel) R1_ACK <= 1'b1;
                        else       R0_ACK <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a small
// behavioural memory; extra instances cover ACCESS_CYCLES 1 and 15.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AC = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          R0_REQ = 0, R0_WRITE = 0, R1_REQ = 0, R1_WRITE = 0;
    logic [AW-1:0] R0_ADDR = '0, R1_ADDR = '0;
    logic [DW-1:0] R0_WDATA = '0, R1_WDATA = '0;
    logic [DW-1:0] R0_RDATA, R1_RDATA;
    logic          R0_ACK, R1_ACK, READ, WRITE;
    logic [AW-1:0] ADDR;
    wire  [DW-1:0] DATA;

    mem_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .CLK(CLK), .RST(RST),
        .R0_REQ(R0_REQ), .R0_WRITE(R0_WRITE), .R0_ADDR(R0_ADDR),
        .R0_WDATA(R0_WDATA), .R0_RDATA(R0_RDATA), .R0_ACK(R0_ACK),
        .R1_REQ(R1_REQ), .R1_WRITE(R1_WRITE), .R1_ADDR(R1_ADDR),
        .R1_WDATA(R1_WDATA), .R1_RDATA(R1_RDATA), .R1_ACK(R1_ACK),
        .ADDR(ADDR), .READ(READ), .WRITE(WRITE), .DATA(DATA)
    );

    // short/long access instances, write-only traffic from R0
    logic          x_req1 = 0, x_req15 = 0;
    logic [DW-1:0] x_r0d1, x_r1d1, x_r0d15, x_r1d15;
    logic          x_a01, x_a11, x_a015, x_a115;
    logic [AW-1:0] x_ad1, x_ad15;
    logic          x_rd1, x_wr1, x_rd15, x_wr15;
    wire  [DW-1:0] x_d1, x_d15;
    localparam logic [AW-1:0] XA = AW'(32'h0100_0010);
    localparam logic [DW-1:0] XD = DW'(32'h3C3C_1234);

    mem_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .R0_REQ(x_req1), .R0_WRITE(1'b1), .R0_ADDR(XA),
        .R0_WDATA(XD), .R0_RDATA(x_r0d1), .R0_ACK(x_a01),
        .R1_REQ(1'b0), .R1_WRITE(1'b0), .R1_ADDR('0),
        .R1_WDATA('0), .R1_RDATA(x_r1d1), .R1_ACK(x_a11),
        .ADDR(x_ad1), .READ(x_rd1), .WRITE(x_wr1), .DATA(x_d1)
    );

    mem_arbiter #(.ACCESS_CYCLES(15)) dut15 (
        .CLK(CLK), .RST(RST),
        .R0_REQ(x_req15), .R0_WRITE(1'b1), .R0_ADDR(XA),
        .R0_WDATA(XD), .R0_RDATA(x_r0d15), .R0_ACK(x_a015),
        .R1_REQ(1'b0), .R1_WRITE(1'b0), .R1_ADDR('0),
        .R1_WDATA('0), .R1_RDATA(x_r1d15), .R1_ACK(x_a115),
        .ADDR(x_ad15), .READ(x_rd15), .WRITE(x_wr15), .DATA(x_d15)
    );

    // behavioural memory, word index ADDR[5:2]
    logic [DW-1:0] mem [16];
    assign DATA = READ ? mem[ADDR[5:2]] : {DW{1'bz}};
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) mem[i] <= DW'(32'h100 + i);
            mem[0] <= DW'(32'h5);
        end else if (WRITE) begin
            mem[ADDR[5:2]] <= DATA;
        end
    end

    logic [DW-1:0] exp_mem [16];
    task automatic exp_init();
        for (int i = 0; i < 16; i++) exp_mem[i] = DW'(32'h100 + i);
        exp_mem[0] = DW'(32'h5);
    endtask

    typedef struct {
        logic          who;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // per-cycle bus rules plus scoreboard pop on every ACK
    always @(negedge CLK) begin
        if (!RST) begin
            n_chk++;
            if ((READ & WRITE) !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_wr_excl: READ=%b WRITE=%b need not both", READ, WRITE);
            end
            n_chk++;
            if ((R0_ACK & R1_ACK) !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_excl: R0_ACK=%b R1_ACK=%b", R0_ACK, R1_ACK);
            end
            if ((READ | WRITE) && sb.size() > 0) begin
                n_chk++;
                if (ADDR !== sb[0].addr) begin
                    n_fail++;
                    $display("FAIL bus_addr: got %h need %h", ADDR, sb[0].addr);
                end
                if (WRITE) begin
                    n_chk++;
                    if (DATA !== sb[0].data) begin
                        n_fail++;
                        $display("FAIL bus_wdata: got %h need %h", DATA, sb[0].data);
                    end
                end
            end
            if (R0_ACK | R1_ACK) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: R0_ACK=%b R1_ACK=%b need none", R0_ACK, R1_ACK);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (R1_ACK !== e.who) begin
                        n_fail++;
                        $display("FAIL ack_who: got R%0d need R%0d", R1_ACK, e.who);
                    end
                    n_chk++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL ack_cycle: got %0d need %0d", cyc, e.cyc);
                    end
                    if (e.rd) begin
                        n_chk++;
                        if ((e.who ? R1_RDATA : R0_RDATA) !== e.data) begin
                            n_fail++;
                            $display("FAIL rdata: got %h need %h",
                                     e.who ? R1_RDATA : R0_RDATA, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic who, input logic req, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (who) begin
            R1_REQ = req; R1_WRITE = wr; R1_ADDR = a; R1_WDATA = wd;
        end else begin
            R0_REQ = req; R0_WRITE = wr; R0_ADDR = a; R0_WDATA = wd;
        end
    endtask

    task automatic issue(input logic who, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit scr);
        exp_t e;
        int   nb;
        bit   got;
        @(negedge CLK);
        e.who  = who;
        e.rd   = !wr;
        e.addr = a;
        e.data = wr ? wd : exp_mem[a[5:2]];
        e.cyc  = cyc + AC + 1;
        if (wr) exp_mem[a[5:2]] = wd;
        sb.push_back(e);
        drive(who, 1'b1, wr, a, wd);
        nb  = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (READ | WRITE) nb++;
            if (scr) drive(who, 1'b1, ~wr, ~a, ~wd);
            if (who ? R1_ACK : R0_ACK) got = 1;
        end
        drive(who, 1'b0, 1'b0, '0, '0);
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout: R%0d got no ack need ack", who);
        end
        n_chk++;
        if (nb != AC) begin
            n_fail++;
            $display("FAIL strobe_len: got %0d need %0d", nb, AC);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_chk++;
        if ({READ, WRITE, R0_ACK, R1_ACK} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b need 0000", {READ, WRITE, R0_ACK, R1_ACK});
        end
        n_chk++;
        if (ADDR !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h need 0", ADDR);
        end
        n_chk++;
        if ({R0_RDATA, R1_RDATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h need 0", R0_RDATA, R1_RDATA);
        end
        exp_init();
        RST = 1'b0;
    endtask

    task automatic test_read();
        issue(1'b0, 1'b0, AW'(32'h0100_0000), '0, 1'b0);
    endtask

    task automatic test_write();
        issue(1'b1, 1'b1, AW'(32'h0100_0004), DW'(32'hA5A5_A5A5), 1'b0);
        issue(1'b0, 1'b0, AW'(32'h0100_0004), '0, 1'b0);
        n_chk++;
        if (R1_RDATA !== '0) begin
            n_fail++;
            $display("FAIL write_no_rdata: got %h need 0", R1_RDATA);
        end
    endtask

    task automatic test_hold_change();
        issue(1'b0, 1'b1, AW'(32'h0100_0008), DW'(32'h1111_1111), 1'b1);
        issue(1'b1, 1'b0, AW'(32'h0100_0008), '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   na;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            e.who  = 1'b1;
            e.rd   = 1'b1;
            e.addr = AW'(32'h0100_0004);
            e.data = exp_mem[1];
            e.cyc  = cyc + AC + 1 + k * (AC + 2);
            sb.push_back(e);
        end
        drive(1'b1, 1'b1, 1'b0, AW'(32'h0100_0004), '0);
        na = 0;
        for (int i = 0; i < 40 && na < 2; i++) begin
            @(negedge CLK);
            if (R1_ACK) na++;
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        n_chk++;
        if (na != 2) begin
            n_fail++;
            $display("FAIL b2b_acks: got %0d need 2", na);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, AW'(32'h0100_0000), '0);
        @(negedge CLK);
        n_chk++;
        if (READ !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: READ got %b need 1", READ);
        end
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        n_chk++;
        if ({READ, WRITE, R0_ACK, R1_ACK} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ctl: got %b need 0000", {READ, WRITE, R0_ACK, R1_ACK});
        end
        n_chk++;
        if (R0_RDATA !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_rdata: got %h need 0", R0_RDATA);
        end
        RST = 1'b0;
        exp_init();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_chk++;
            if ({R0_ACK, R1_ACK} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_mid_ack: got %b need 00", {R0_ACK, R1_ACK});
            end
        end
    endtask

    task automatic test_tie();
        exp_t e;
        int   na;
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            e.who = k[0];
`else
            e.who = 1'b0;
`endif
            e.rd   = 1'b1;
            e.addr = e.who ? AW'(32'h0100_0004) : AW'(32'h0100_0000);
            e.data = exp_mem[e.who ? 1 : 0];
            e.cyc  = cyc + AC + 1 + k * (AC + 2);
            sb.push_back(e);
        end
        drive(1'b0, 1'b1, 1'b0, AW'(32'h0100_0000), '0);
        drive(1'b1, 1'b1, 1'b0, AW'(32'h0100_0004), '0);
        na = 0;
        for (int i = 0; i < 60 && na < 4; i++) begin
            @(negedge CLK);
            if (R0_ACK | R1_ACK) na++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        n_chk++;
        if (na != 4) begin
            n_fail++;
            $display("FAIL tie_acks: got %0d need 4", na);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_latency_ext();
        int m, a1, a15, w1, w15;
        @(negedge CLK);
        m  = cyc;
        a1 = -1; a15 = -1; w1 = 0; w15 = 0;
        x_req1  = 1'b1;
        x_req15 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (x_wr1)  w1++;
            if (x_wr15) w15++;
            if (x_wr1 && (x_d1 !== XD || x_ad1 !== XA)) begin
                n_fail++;
                $display("FAIL ac1_bus: got %h@%h need %h@%h", x_d1, x_ad1, XD, XA);
            end
            if (x_wr15 && (x_d15 !== XD || x_ad15 !== XA)) begin
                n_fail++;
                $display("FAIL ac15_bus: got %h@%h need %h@%h", x_d15, x_ad15, XD, XA);
            end
            if (x_rd1 | x_rd15 | x_a11 | x_a115) begin
                n_fail++;
                $display("FAIL ext_spurious: got %b need 0000", {x_rd1, x_rd15, x_a11, x_a115});
            end
            if (x_a01 && a1 < 0) begin
                a1 = cyc;
                x_req1 = 1'b0;
            end
            if (x_a015 && a15 < 0) begin
                a15 = cyc;
                x_req15 = 1'b0;
            end
        end
        x_req1  = 1'b0;
        x_req15 = 1'b0;
        n_chk++;
        if (a1 != m + 2) begin
            n_fail++;
            $display("FAIL ac1_ack: got cycle %0d need %0d", a1 - m, 2);
        end
        n_chk++;
        if (a15 != m + 16) begin
            n_fail++;
            $display("FAIL ac15_ack: got cycle %0d need %0d", a15 - m, 16);
        end
        n_chk++;
        if (w1 != 1 || w15 != 15) begin
            n_fail++;
            $display("FAIL ext_strobe: got %0d/%0d need 1/15", w1, w15);
        end
        n_chk++;
        if ({x_r0d1, x_r1d1, x_r0d15, x_r1d15} !== '0) begin
            n_fail++;
            $display("FAIL ext_rdata: got nonzero need 0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running need finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_hold_change();
        test_back_to_back();
        test_reset_mid();
        test_tie();
        test_latency_ext();
        repeat (2) @(negedge CLK);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ACCESS_CYCLES, 2, cycles memory strobe is held per access (legal 1..15).
REQ-002 SHALL have port: CLK  input  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port: RST  input  1  synchronous active-high reset.
REQ-004 SHALL have ports: R0_REQ / R1_REQ  input  1 each  access request, held until ACK.
REQ-005 SHALL have ports: R0_WRITE / R1_WRITE  input  1 each  1=write, 0=read.
REQ-006 SHALL have ports: R0_ADDR / R1_ADDR  input  `ADDRESS_INDEX_LIMIT+1 each  word address.
REQ-007 SHALL have ports: R0_WDATA / R1_WDATA  input  `DATA_INDEX_LIMIT+1 each  write data.
REQ-008 SHALL have ports: R0_RDATA / R1_RDATA  output  `DATA_INDEX_LIMIT+1 each  registered read data.
REQ-009 SHALL have ports: R0_ACK / R1_ACK  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports: ADDR  output  `ADDRESS_INDEX_LIMIT+1, READ  output  1, WRITE  output  1  memory-side bus.
REQ-011 SHALL have port: DATA  inout  `DATA_INDEX_LIMIT+1  memory data; driven only while WRITE=1, else high-Z.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-013 IDLE: any REQ high -> select winner, latch its ADDR/WRITE/WDATA, load counter=ACCESS_CYCLES-1, go ACCESS; no REQ -> stay IDLE.
REQ-014 ACCESS: drive ADDR from latch; READ=~wr, WRITE=wr; counter!=0 -> decrement, stay; counter==0 -> go DONE.
REQ-015 Read data SHALL be captured from DATA into winner's RDATA at the edge leaving ACCESS; other RDATA unchanged; writes leave RDATA unchanged.
REQ-016 DONE: READ=WRITE=0, DATA high-Z, winner's ACK=1 for exactly one cycle, go IDLE.
REQ-017 Latency: REQ seen in IDLE at cycle k -> ACCESS cycles k+1..k+ACCESS_CYCLES -> ACK in cycle k+ACCESS_CYCLES+1.
REQ-018 READ and WRITE SHALL never be high simultaneously; both low outside ACCESS.
REQ-019 Requester inputs SHALL be ignored after latching; changes mid-access have no effect.
REQ-020 REQ still high in the cycle after ACK SHALL be treated as a new request.
REQ-021 Loser's REQ SHALL remain pending with no ACK until it is granted.
REQ-022 At most one ACK SHALL be high in any cycle.

Reset
REQ-023 On RST=1 at an edge: state=IDLE, counter=0, READ=WRITE=0, ADDR=0, DATA high-Z, both ACK=0, both RDATA=0, last-grant=1.
REQ-024 Reset mid-ACCESS or in DONE SHALL abort the access with no ACK and no RDATA update.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests grant the requester not granted last; last-grant updated on each grant.
REQ-026 Macro undefined: fixed priority, R0 always wins ties; last-grant register absent.
REQ-027 Single-requester behaviour SHALL be identical in both builds.

Structure
REQ-028 Widths SHALL come from `ADDRESS_INDEX_LIMIT/`DATA_INDEX_LIMIT in prj_definition.v; FSM state encodings (2-bit) SHALL be defined there too.
REQ-029 Grant selection SHALL be one sub-module, arb_select (inputs: two REQs, last-grant; output: winner index).
REQ-030 Counter SHALL be 4 bits.

Verification
REQ-031 R0 read of 0x01000000 (memory holds 0x5), ACCESS_CYCLES=2, REQ at cycle 0 -> READ high cycles 1-2, R0_RDATA=0x5 and R0_ACK=1 in cycle 3.
REQ-032 R1 write 0xA5A5A5A5 to 0x01000004 -> WRITE high for ACCESS_CYCLES cycles, DATA driven only then, later R0 read returns 0xA5A5A5A5.
REQ-033 R0 and R1 requesting together, held, round-robin build -> grants R0, R1, R0, R1; fixed build -> R0 serviced continuously, R1 starved.
REQ-034 RST=1 asserted in middle ACCESS cycle -> next cycle READ=WRITE=0, no ACK, RDATA=0, DATA high-Z.
REQ-035 ACCESS_CYCLES=1 and 15 -> ACK at cycle 2 and cycle 16 respectively after REQ at cycle 0.
REQ-036 R0 changes ADDR/WDATA during ACCESS -> bus ADDR/DATA unchanged until DONE.
